// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the clocked instruction memory.
// No logic of its own; the fault encoding and FSM states are the public contract.
// fetch_fault_of() sets misaligned above out-of-range so the two faults never combine.
package inst_mem_pkg;

    // ADDI x0,x0,0: fill word after the init sweep and the instruction returned on a fault.
    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_RANGE    = 2'b10
    } fault_e;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // A misaligned address reports as misaligned even when it is also out of range.
    function automatic fault_e fetch_fault_of(input logic [1:0] byte_off, input logic in_range);
        if (byte_off != 2'b00) return FLT_MISALIGN;
        if (!in_range)         return FLT_RANGE;
        return FLT_NONE;
    endfunction

endpackage

// File: rtl/inst_mem_bank.sv
// 1R1W synchronous word array (DEPTH x XLEN) with a registered read port.
// Latency: rd_data updates on the edge that samples rd_en; a write is visible to reads from the next edge.
// Backpressure: none. Both ports act every cycle their enable is high.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read request; rd_data registered read data.
// rd_data holds its value when rd_en is low. The caller keeps both addresses below DEPTH.
module inst_mem_bank #(
    parameter int DEPTH = 1024,
    parameter int XLEN  = 32,
    parameter int AW    = 10
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output logic [XLEN-1:0] rd_data
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/inst_mem_sync.sv
// Clocked instruction memory: pipelined fetch port with fault reporting, a word program port and a NOP self-init sweep.
// Latency: fetch_valid pulses READ_LAT (1 or 2) cycles after accept. Back-to-back accepts are fully pipelined.
// Backpressure: fetch_ready is low during the init sweep and in any prog_we cycle. Responses cannot be stalled.
// Ports: clk, rst_n (async active-low); fetch_req/fetch_addr/fetch_ready request; fetch_flush;
//        fetch_valid/fetch_inst/fetch_fault response; prog_we/prog_addr/prog_wdata program write; init_done.
module inst_mem_sync #(
    parameter int              ADDR_W   = 12,
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 1024,
    parameter int              READ_LAT = 1,
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(inst_mem_pkg::NOP_INST)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    input  logic              fetch_flush,
    output logic              fetch_valid,
    output logic [XLEN-1:0]   fetch_inst,
    output logic [1:0]        fetch_fault,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [XLEN-1:0]   prog_wdata,
    output logic              init_done
);

    import inst_mem_pkg::*;

    localparam int           IW      = ADDR_W - 2;
    localparam int           AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW:0]  DEPTH_L = (IW+1)'(DEPTH);
    localparam logic [0:0]   ST_INIT = INIT;
    localparam logic [0:0]   ST_RUN  = RUN;

    if (!(READ_LAT == 1 || READ_LAT == 2)) begin : g_bad_lat
        $error("inst_mem_sync: READ_LAT must be 1 or 2");
    end
    if (DEPTH <= 1 || DEPTH > (1 << IW)) begin : g_bad_depth
        $error("inst_mem_sync: DEPTH must satisfy 1 < DEPTH <= 2**(ADDR_W-2)");
    end

    // ---------------- init FSM ----------------
    logic [0:0]    state_q;
    logic [AW-1:0] init_cnt_q;
    logic          in_run;

    assign in_run    = (state_q == ST_RUN);
    assign init_done = in_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else if (!in_run) begin
            // The last sweep write and the move to RUN happen on the same edge.
            if (init_cnt_q == AW'(DEPTH - 1)) begin
                state_q <= ST_RUN;
            end else begin
                init_cnt_q <= init_cnt_q + AW'(1);
            end
        end
    end

    // ---------------- fetch accept and fault ----------------
    logic [IW-1:0] fetch_idx;
    logic          fetch_in_range;
    logic [1:0]    acc_fault;
    logic          accept;
    logic          rd_en;

    assign fetch_idx      = fetch_addr[ADDR_W-1:2];
    assign fetch_in_range = ({1'b0, fetch_idx} < DEPTH_L);
    assign acc_fault      = fetch_fault_of(fetch_addr[1:0], fetch_in_range);
    assign fetch_ready    = in_run & ~prog_we;
    assign accept         = fetch_req & fetch_ready;
    // A faulted fetch never touches the array.
    assign rd_en          = accept & (acc_fault == FLT_NONE);

    // ---------------- shared write port ----------------
    logic [IW-1:0]   prog_idx;
    logic            prog_in_range;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            unused_prog_lsb;

    assign prog_idx        = prog_addr[ADDR_W-1:2];
    assign prog_in_range   = ({1'b0, prog_idx} < DEPTH_L);
    assign unused_prog_lsb = ^prog_addr[1:0];

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = init_cnt_q;
        wr_data = NOP_INST;
        if (!in_run) begin
            wr_en = 1'b1;
        end else if (prog_we && prog_in_range) begin
            wr_en   = 1'b1;
            wr_addr = prog_idx[AW-1:0];
            wr_data = prog_wdata;
        end
    end

    logic [XLEN-1:0] rd_data;

    inst_mem_bank #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .AW    (AW)
    ) u_bank (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (fetch_idx[AW-1:0]),
        .rd_data (rd_data)
    );

    // ---------------- stage 1: alongside the array read ----------------
    logic            s1_vld_q;
    logic [1:0]      s1_fault_q;
    logic            s1_nop_q;
    logic [XLEN-1:0] s1_inst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_fault_q <= FLT_NONE;
            s1_nop_q   <= 1'b1;
        end else begin
            // A flush only kills older work. An accept in the flush cycle still enters.
            s1_vld_q <= accept;
            if (accept) begin
                s1_fault_q <= acc_fault;
                s1_nop_q   <= (acc_fault != FLT_NONE);
            end
        end
    end

    // The NOP flag starts at 1 so the pre-read array register never reaches the port.
    assign s1_inst = s1_nop_q ? NOP_INST : rd_data;

    // The flush gate on fetch_valid is combinational. Otherwise a response accepted
    // before the flush would still pulse in the flush cycle itself.
    if (READ_LAT == 2) begin : g_lat2
        logic            s2_vld_q;
        logic [XLEN-1:0] s2_inst_q;
        logic [1:0]      s2_fault_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_vld_q   <= 1'b0;
                s2_inst_q  <= NOP_INST;
                s2_fault_q <= FLT_NONE;
            end else begin
                s2_vld_q <= s1_vld_q & ~fetch_flush;
                if (s1_vld_q && !fetch_flush) begin
                    s2_inst_q  <= s1_inst;
                    s2_fault_q <= s1_fault_q;
                end
            end
        end

        assign fetch_valid = s2_vld_q & ~fetch_flush;
        assign fetch_inst  = s2_inst_q;
        assign fetch_fault = s2_fault_q;
    end else begin : g_lat1
        assign fetch_valid = s1_vld_q & ~fetch_flush;
        assign fetch_inst  = s1_inst;
        assign fetch_fault = s1_fault_q;
    end

endmodule

// File: tb/tb_inst_mem_sync.sv
// Bench for inst_mem_sync. DEPTH=16. Two instances (READ_LAT 1 and 2) share one stimulus.
// A queue/array model predicts every response. Directed literals pin the key scenarios.
module tb_inst_mem_sync;

    localparam int          DEPTH = 16;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [11:0] fetch_addr = '0;
    logic        fetch_flush = 1'b0;
    logic        prog_we = 1'b0;
    logic [11:0] prog_addr = '0;
    logic [31:0] prog_wdata = '0;

    logic        ready1, valid1, init1, ready2, valid2, init2;
    logic [31:0] inst1, inst2;
    logic [1:0]  fault1, fault2;

    always #5 clk = ~clk;

    inst_mem_sync #(.ADDR_W(12), .XLEN(32), .DEPTH(DEPTH), .READ_LAT(1), .NOP_INST(NOP)) dut1 (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(ready1), .fetch_flush(fetch_flush), .fetch_valid(valid1),
        .fetch_inst(inst1), .fetch_fault(fault1), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .init_done(init1));

    inst_mem_sync #(.ADDR_W(12), .XLEN(32), .DEPTH(DEPTH), .READ_LAT(2), .NOP_INST(NOP)) dut2 (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(ready2), .fetch_flush(fetch_flush), .fetch_valid(valid2),
        .fetch_inst(inst2), .fetch_fault(fault2), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .init_done(init2));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int due; logic [31:0] inst; logic [1:0] fault; } rsp_t;
    typedef struct { int stamp; logic [31:0] inst; logic [1:0] fault; } log_t;

    rsp_t        q1[$], q2[$];
    log_t        log1[$], log2[$];
    logic [31:0] mem_m [DEPTH];
    int          since = 0;   // cycles completed since reset release, saturates at DEPTH
    int          cyc = 0;     // index of the current cycle
    int          init_rise = -1;
    logic        prev_init = 1'b0;

    always @(posedge clk) begin : model
        bit          run;
        int          idx;
        rsp_t        r;
        if (!rst_n) begin
            since = 0;
            q1.delete();
            q2.delete();
            for (int i = 0; i < DEPTH; i++) mem_m[i] = NOP;
        end else begin
            run = (since >= DEPTH);
            if (fetch_flush) begin
                q1.delete();
                q2.delete();
            end else begin
                if (q1.size() > 0 && q1[0].due == cyc) void'(q1.pop_front());
                if (q2.size() > 0 && q2[0].due == cyc) void'(q2.pop_front());
            end
            if (run && fetch_req && !prog_we) begin
                idx = int'(fetch_addr[11:2]);
                if (fetch_addr[1:0] != 2'b00) begin r.fault = 2'b01; r.inst = NOP; end
                else if (idx >= DEPTH)        begin r.fault = 2'b10; r.inst = NOP; end
                else                          begin r.fault = 2'b00; r.inst = mem_m[idx]; end
                r.due = cyc + 1; q1.push_back(r);
                r.due = cyc + 2; q2.push_back(r);
            end
            if (run && prog_we && int'(prog_addr[11:2]) < DEPTH)
                mem_m[int'(prog_addr[11:2])] = prog_wdata;
            if (since < DEPTH) since++;
        end
        cyc++;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        bit run, ev1, ev2;
        if (!rst_n) begin
            chk("rst_valid1", 32'(valid1), 32'd0);
            chk("rst_valid2", 32'(valid2), 32'd0);
            chk("rst_ready1", 32'(ready1), 32'd0);
            chk("rst_ready2", 32'(ready2), 32'd0);
            chk("rst_init1", 32'(init1), 32'd0);
            chk("rst_init2", 32'(init2), 32'd0);
            chk("rst_inst1", inst1, NOP);
            chk("rst_inst2", inst2, NOP);
            chk("rst_fault1", 32'(fault1), 32'd0);
            chk("rst_fault2", 32'(fault2), 32'd0);
            prev_init = 1'b0;
        end else begin
            run = (since >= DEPTH);
            chk("ready1", 32'(ready1), 32'(run && !prog_we));
            chk("ready2", 32'(ready2), 32'(run && !prog_we));
            chk("init1", 32'(init1), 32'(run));
            chk("init2", 32'(init2), 32'(run));
            ev1 = (q1.size() > 0) && (q1[0].due == cyc) && !fetch_flush;
            ev2 = (q2.size() > 0) && (q2[0].due == cyc) && !fetch_flush;
            chk("valid1", 32'(valid1), 32'(ev1));
            chk("valid2", 32'(valid2), 32'(ev2));
            if (ev1) begin
                chk("inst1", inst1, q1[0].inst);
                chk("fault1", 32'(fault1), 32'(q1[0].fault));
            end
            if (ev2) begin
                chk("inst2", inst2, q2[0].inst);
                chk("fault2", 32'(fault2), 32'(q2[0].fault));
            end
            if (valid1) log1.push_back('{cyc, inst1, fault1});
            if (valid2) log2.push_back('{cyc, inst2, fault2});
            if (init1 && !prev_init) init_rise = cyc;
            prev_init = init1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [11:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = a; prog_wdata = d;
        tick(1);
        prog_we = 1'b0;
    endtask

    task automatic fetch(input logic [11:0] a);
        fetch_req = 1'b1; fetch_addr = a;
        tick(1);
        fetch_req = 1'b0;
    endtask

    int rel;
    int t0;

    initial begin
        // Test 1: reset release, init sweep, first fetch. INIT ignores prog and fetch.
        tick(3);
        rst_n = 1'b1; rel = cyc;
        tick(5);
        prog_we = 1'b1; prog_addr = 12'h008; prog_wdata = 32'hDEADBEEF;
        fetch_req = 1'b1; fetch_addr = 12'h000;
        tick(1);
        prog_we = 1'b0; fetch_req = 1'b0;
        tick(10);
        log1.delete(); log2.delete();
        t0 = cyc;
        fetch(12'h000);
        fetch(12'h008);
        tick(3);
        chk("init_rise_cycle", 32'(init_rise - rel), 32'd16);
        chk("t1_count", 32'(log1.size()), 32'd2);
        if (log1.size() == 2) begin
            chk("t1_stamp", 32'(log1[0].stamp), 32'(t0 + 1));
            chk("t1_inst0", log1[0].inst, 32'h00000013);
            chk("t1_fault0", 32'(log1[0].fault), 32'd0);
            chk("t1_init_prog_ignored", log1[1].inst, 32'h00000013);
        end

        // Test 2: program then fetch. A fetch in a prog_we cycle is refused.
        log1.delete();
        prog_we = 1'b1; prog_addr = 12'h00C; prog_wdata = 32'h002080B3;
        fetch_req = 1'b1; fetch_addr = 12'h00C;
        #1;
        chk("t2_ready_in_prog", 32'(ready1), 32'd0);
        tick(1);
        prog_we = 1'b0;
        t0 = cyc;
        fetch(12'h00C);
        tick(3);
        chk("t2_count", 32'(log1.size()), 32'd1);
        if (log1.size() == 1) begin
            chk("t2_inst", log1[0].inst, 32'h002080B3);
            chk("t2_stamp", 32'(log1[0].stamp), 32'(t0 + 1));
        end

        // Test 3: faults, last in-range word, dropped out-of-range write (no alias onto word 0).
        prog(12'h03C, 32'hCAFEF00D);
        prog(12'h040, 32'h11111111);
        log1.delete();
        fetch(12'h006);
        fetch(12'h040);
        fetch(12'h042);
        fetch(12'h03C);
        fetch(12'h000);
        tick(3);
        chk("t3_count", 32'(log1.size()), 32'd5);
        if (log1.size() == 5) begin
            chk("t3_fault_006", 32'(log1[0].fault), 32'd1);
            chk("t3_inst_006", log1[0].inst, 32'h00000013);
            chk("t3_fault_040", 32'(log1[1].fault), 32'd2);
            chk("t3_fault_042", 32'(log1[2].fault), 32'd1);
            chk("t3_inst_03C", log1[3].inst, 32'hCAFEF00D);
            chk("t3_no_alias", log1[4].inst, 32'h00000013);
        end

        // Test 4: READ_LAT=2 back-to-back fetches.
        prog(12'h000, 32'hA0A0A0A0);
        prog(12'h004, 32'hB1B1B1B1);
        prog(12'h008, 32'hC2C2C2C2);
        log2.delete();
        t0 = cyc;
        fetch_req = 1'b1; fetch_addr = 12'h000; tick(1);
        fetch_addr = 12'h004; tick(1);
        fetch_addr = 12'h008; tick(1);
        fetch_req = 1'b0;
        tick(4);
        chk("t4_count", 32'(log2.size()), 32'd3);
        if (log2.size() == 3) begin
            chk("t4_stamp0", 32'(log2[0].stamp), 32'(t0 + 2));
            chk("t4_stamp1", 32'(log2[1].stamp), 32'(t0 + 3));
            chk("t4_stamp2", 32'(log2[2].stamp), 32'(t0 + 4));
            chk("t4_inst0", log2[0].inst, 32'hA0A0A0A0);
            chk("t4_inst1", log2[1].inst, 32'hB1B1B1B1);
            chk("t4_inst2", log2[2].inst, 32'hC2C2C2C2);
        end

        // Test 5: flush with two fetches in flight, plus a new request in the flush cycle.
        prog(12'h010, 32'hD3D3D3D3);
        log1.delete(); log2.delete();
        t0 = cyc;
        fetch_req = 1'b1; fetch_addr = 12'h000; tick(1);
        fetch_addr = 12'h004; tick(1);
        fetch_flush = 1'b1; fetch_addr = 12'h010; tick(1);
        fetch_flush = 1'b0; fetch_req = 1'b0;
        tick(4);
        chk("t5_count2", 32'(log2.size()), 32'd1);
        if (log2.size() == 1) begin
            chk("t5_inst2", log2[0].inst, 32'hD3D3D3D3);
            chk("t5_stamp2", 32'(log2[0].stamp), 32'(t0 + 4));
        end
        chk("t5_count1", 32'(log1.size()), 32'd2);
        if (log1.size() == 2) chk("t5_inst1", log1[1].inst, 32'hD3D3D3D3);

        // Test 6: reset pulse in init cycle 7 restarts the sweep and wipes programmed data.
        rst_n = 1'b0; tick(1);
        rst_n = 1'b1; rel = cyc;
        tick(7);
        rst_n = 1'b0; tick(1);
        rst_n = 1'b1; rel = cyc;
        tick(16);
        log1.delete();
        fetch(12'h00C);
        tick(3);
        chk("t6_init_rise", 32'(init_rise - rel), 32'd16);
        chk("t6_count", 32'(log1.size()), 32'd1);
        if (log1.size() == 1) chk("t6_prog_lost", log1[0].inst, 32'h00000013);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
